// File: rtl/seg7_scan_driver_if.sv
// Bundle between the stopwatch counter and the seven-segment scan driver.
// master: the upstream side (drives BCD digits and display controls,
//         observes the display pins and status).
// slave : the scan driver (consumes the digits, drives the display pins).
// Signals: sec_lsb..hr_msb (4-bit BCD each), blank_lz, dp_en,
//          seg[6:0] {g,f,e,d,c,b,a}, dp, an[5:0], frame_done, bad_digit.
interface seg7_scan_driver_if;
  logic [3:0] sec_lsb;
  logic [3:0] sec_msb;
  logic [3:0] min_lsb;
  logic [3:0] min_msb;
  logic [3:0] hr_lsb;
  logic [3:0] hr_msb;
  logic       blank_lz;
  logic       dp_en;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_done;
  logic       bad_digit;

  modport master (
    output sec_lsb, sec_msb, min_lsb, min_msb, hr_lsb, hr_msb, blank_lz, dp_en,
    input  seg, dp, an, frame_done, bad_digit
  );

  modport slave (
    input  sec_lsb, sec_msb, min_lsb, min_msb, hr_lsb, hr_msb, blank_lz, dp_en,
    output seg, dp, an, frame_done, bad_digit
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Six-digit time-multiplexed seven-segment display driver.
// Scans an[0] (sec_lsb) .. an[5] (hr_msb), one digit per SCAN_DIV cycles,
// with BLANK_CYC all-off cycles at the start of every slot. Digits are
// snapshotted once per frame (at the 5->0 wrap) so a frame never tears.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   bus   - slave side of seg7_scan_driver_if (digits in, display pins out)
module seg7_scan_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_driver_if.slave  bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic POL = ACTIVE_LOW;

  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       idx_reg;
  logic [5:0][3:0]  shadow_reg;
  logic [5:0][3:0]  digit_in;
  logic [5:0]       digit_bad;
  logic             frame_done_reg;
  logic             bad_digit_reg;
  logic [5:0]       an_reg;
  logic [6:0]       seg_reg;
  logic             dp_reg;

  logic             cnt_wrap;
  logic             frame_wrap;
  logic [3:0]       cur_digit;
  logic [5:0]       an_next;
  logic [6:0]       seg_next;
  logic             dp_next;

  assign digit_in[0] = bus.sec_lsb;
  assign digit_in[1] = bus.sec_msb;
  assign digit_in[2] = bus.min_lsb;
  assign digit_in[3] = bus.min_msb;
  assign digit_in[4] = bus.hr_lsb;
  assign digit_in[5] = bus.hr_msb;

  // Out-of-range check on the values about to be captured.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_bad
      assign digit_bad[gi] = (digit_in[gi] > 4'd9);
    end
  endgenerate

  assign cnt_wrap   = (cnt_reg == CNT_W'(SCAN_DIV - 1));
  assign frame_wrap = cnt_wrap && (idx_reg == 3'd5);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;  // dash for non-BCD values
    endcase
  endfunction

  // Divider and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (cnt_wrap) begin
      cnt_reg <= '0;
      idx_reg <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Frame snapshot and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_reg     <= '0;
      frame_done_reg <= 1'b0;
      bad_digit_reg  <= 1'b0;
    end else begin
      frame_done_reg <= frame_wrap;
      if (frame_wrap) begin
        shadow_reg    <= digit_in;
        bad_digit_reg <= bad_digit_reg | (|digit_bad);
      end
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    case (idx_reg)
      3'd0:    cur_digit = shadow_reg[0];
      3'd1:    cur_digit = shadow_reg[1];
      3'd2:    cur_digit = shadow_reg[2];
      3'd3:    cur_digit = shadow_reg[3];
      3'd4:    cur_digit = shadow_reg[4];
      3'd5:    cur_digit = shadow_reg[5];
      default: cur_digit = 4'd0;
    endcase
  end

  // Slot control in active-high form; polarity applied at the registers.
  always_comb begin
    an_next  = '0;
    seg_next = '0;
    dp_next  = 1'b0;
    if (cnt_reg >= CNT_W'(BLANK_CYC)) begin
      an_next = 6'b000001 << idx_reg;
      // Leading hour zero: anode keeps its timing, segments stay dark.
      if (!(bus.blank_lz && (idx_reg == 3'd5) && (cur_digit == 4'd0))) begin
        seg_next = decode(cur_digit);
      end
      dp_next = bus.dp_en && ((idx_reg == 3'd2) || (idx_reg == 3'd4));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_reg  <= {6{POL}};
      seg_reg <= {7{POL}};
      dp_reg  <= POL;
    end else begin
      an_reg  <= an_next ^ {6{POL}};
      seg_reg <= seg_next ^ {7{POL}};
      dp_reg  <= dp_next ^ POL;
    end
  end

  assign bus.an         = an_reg;
  assign bus.seg        = seg_reg;
  assign bus.dp         = dp_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.bad_digit  = bad_digit_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (active-low and active-high)
// share one stimulus; a cycle-level reference model predicts the pins.
module tb_seg7_scan_driver;
  localparam int S = 8;
  localparam int B = 2;
  localparam int FRAME = 6 * S;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       bad;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] dig [6];
  logic blank_lz = 1'b1;
  logic dp_en = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];
  logic [6:0] seg_tab [16];
  logic [3:0] m_shadow [6];
  logic m_bad = 1'b0;
  int n_edge = 0;
  int cur_slot = 0;
  int cur_cnt = 0;

  seg7_scan_driver_if bus_lo ();
  seg7_scan_driver_if bus_hi ();

  assign bus_lo.sec_lsb = dig[0];
  assign bus_lo.sec_msb = dig[1];
  assign bus_lo.min_lsb = dig[2];
  assign bus_lo.min_msb = dig[3];
  assign bus_lo.hr_lsb  = dig[4];
  assign bus_lo.hr_msb  = dig[5];
  assign bus_lo.blank_lz = blank_lz;
  assign bus_lo.dp_en    = dp_en;
  assign bus_hi.sec_lsb = dig[0];
  assign bus_hi.sec_msb = dig[1];
  assign bus_hi.min_lsb = dig[2];
  assign bus_hi.min_msb = dig[3];
  assign bus_hi.hr_lsb  = dig[4];
  assign bus_hi.hr_msb  = dig[5];
  assign bus_hi.blank_lz = blank_lz;
  assign bus_hi.dp_en    = dp_en;

  seg7_scan_driver #(.SCAN_DIV(S), .BLANK_CYC(B), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .reset(reset), .bus(bus_lo)
  );
  seg7_scan_driver #(.SCAN_DIV(S), .BLANK_CYC(B), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .bus(bus_hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Reference model: position p = n-1 after edge n; frames load digits at
  // every edge that is a multiple of the frame length.
  initial begin
    exp_t e;
    int p;
    logic [3:0] d;
    seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    for (int i = 0; i < 6; i++) m_shadow[i] = 4'd0;
    forever begin
      @(posedge clk);
      if (reset) begin
        n_edge = 0;
        m_bad = 1'b0;
        for (int i = 0; i < 6; i++) m_shadow[i] = 4'd0;
      end else begin
        n_edge++;
        p = n_edge - 1;
        cur_cnt = p % S;
        cur_slot = (p / S) % 6;
        e = '0;
        if (cur_cnt >= B) begin
          e.an = 6'(1 << cur_slot);
          d = m_shadow[cur_slot];
          e.seg = (blank_lz && cur_slot == 5 && d == 4'd0) ? 7'd0 : seg_tab[d];
          e.dp = dp_en && (cur_slot == 2 || cur_slot == 4);
        end
        if (n_edge % FRAME == 0) begin
          for (int i = 0; i < 6; i++) begin
            m_shadow[i] = dig[i];
            if (dig[i] > 4'd9) m_bad = 1'b1;
          end
          e.fd = 1'b1;
        end
        e.bad = m_bad;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: pops the prediction for this cycle and compares both polarities.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!reset) begin
          check("pins_active_low",
                {1'b0, bus_lo.an, bus_lo.seg, bus_lo.dp, bus_lo.frame_done, bus_lo.bad_digit},
                {1'b0, ~e.an, ~e.seg, ~e.dp, e.fd, e.bad});
          check("pins_active_high",
                {1'b0, bus_hi.an, bus_hi.seg, bus_hi.dp, bus_hi.frame_done, bus_hi.bad_digit},
                {1'b0, e.an, e.seg, e.dp, e.fd, e.bad});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  task automatic check_reset_pins(input string name);
    check({name, "_lo"},
          {1'b0, bus_lo.an, bus_lo.seg, bus_lo.dp, bus_lo.frame_done, bus_lo.bad_digit},
          {1'b0, 6'h3F, 7'h7F, 1'b1, 1'b0, 1'b0});
    check({name, "_hi"},
          {1'b0, bus_hi.an, bus_hi.seg, bus_hi.dp, bus_hi.frame_done, bus_hi.bad_digit},
          16'h0000);
  endtask

  task automatic wait_slot(input int slot, input string name);
    int k;
    k = 0;
    while (!(cur_slot == slot && cur_cnt >= B) && k < 4 * FRAME) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k >= 4 * FRAME) begin
      n_bad++;
      $display("FAIL %s timeout actual=%0d required=%0d", name, cur_slot, slot);
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) dig[i] = 4'd0;
    #17;
    check_reset_pins("reset_init");
    run(2);
    reset = 1'b0;

    // 12:34:56 with separators on and leading-zero blanking enabled.
    dig[0] = 4'd6; dig[1] = 4'd5; dig[2] = 4'd4;
    dig[3] = 4'd3; dig[4] = 4'd2; dig[5] = 4'd1;
    run(3 * FRAME);

    // No tearing: min_lsb 3 -> 7 while slot 1 is being shown.
    dig[2] = 4'd3;
    run(FRAME);
    wait_slot(1, "wait_slot1");
    dig[2] = 4'd7;
    run(2 * FRAME);

    // Leading zero handling.
    dig[5] = 4'd0; blank_lz = 1'b1;
    run(2 * FRAME);
    blank_lz = 1'b0;
    run(2 * FRAME);
    dig[5] = 4'd1; blank_lz = 1'b1;
    run(FRAME + S);
    blank_lz = 1'b0; dp_en = 1'b0;
    run(FRAME);
    dp_en = 1'b1;

    // Random BCD traffic with live control changes.
    for (int c = 0; c < 6 * FRAME; c++) begin
      tick();
      if ($urandom_range(0, 7) == 0) dig[$urandom_range(0, 5)] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 30) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 30) == 0) dp_en = 1'($urandom);
    end

    // Decode sweep on sec_lsb; values above 9 make bad_digit stick.
    for (int v = 0; v < 16; v++) begin
      dig[0] = 4'(v);
      run(FRAME);
    end
    dig[0] = 4'd2;
    run(FRAME);

    // Reset while an[3] is lit: everything off and flags cleared at once.
    wait_slot(3, "wait_slot3");
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_pins("reset_mid");
    run(3);
    reset = 1'b0;

    // Full-range random digits after restart.
    for (int c = 0; c < 4 * FRAME; c++) begin
      tick();
      if ($urandom_range(0, 5) == 0) dig[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 20) == 0) blank_lz = 1'($urandom);
    end
    run(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
